mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Pipeline MEM stage. Sits between the EX/MEM pipe register and the MEM/WB pipe register.
- Takes the ALU result as the effective address, plus store data and the memory-control bits.
- Runs a req/ack transaction on the data-memory port, aligns store data and byte enables, and sign/zero-extends load data.
- Holds the pipeline via stall_o until load data is ready for MEM/WB to capture.

Parameters:
- TIMEOUT_CYCLES, 16: max WAIT cycles before abort; 0 = timeout disabled.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  suppresses starting a new access (see Behaviour)
- valid_i  in  1  EX/MEM holds a valid instruction
- mem_read_i  in  1  load
- mem_write_i  in  1  store
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  32  effective address (ALU result)
- wdata_i  in  32  store data, right-aligned
- dmem_req_o  out  1  bus request, registered
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address, {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned store data
- dmem_rdata_i  in  32  read data, valid with ack
- dmem_ack_i  in  1  transaction complete
- stall_o  out  1  hold all upstream stages and MEM/WB
- load_data_o  out  32  extended load result, to MEM/WB Read_Data
- misalign_o  out  1  misaligned-access flag, combinational
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset (async, rst_i=0):
  - state=IDLE, timeout counter=0.
  - dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, load_data_o, bus_err_o all 0.
  - A transaction in flight is dropped: req falls immediately.
- start = state==IDLE & valid_i & (mem_read_i|mem_write_i) & !flush_i & !misalign.
- misalign:
  - H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Unsupported funct3 (011,110,111) is treated as misaligned.
  - misalign_o = valid_i & (rd|wr) & misalign, only while state==IDLE.
  - No bus access and no stall on a misaligned access.
- mem_read_i and mem_write_i both 1: treated as a store.
- FSM:
  - IDLE -> WAIT on start. On that edge, register req=1, we, addr, be, wdata.
  - WAIT -> DONE on dmem_ack_i. On that edge, req=0; for loads, load_data_o = extended data.
  - WAIT -> DONE on timeout, when the counter reaches TIMEOUT_CYCLES-1 without ack. On that edge, req=0, load_data_o=0, bus_err_o=1 for one cycle.
  - DONE -> IDLE unconditionally. start is blocked in DONE, so the same instruction is never re-issued.
- stall_o = start | (state==WAIT). It is 0 in DONE, so the pipeline advances at the end of DONE and MEM/WB captures load_data_o.
- Zero-wait memory (ack in first WAIT cycle): 2 stall cycles, data captured at the end of the third cycle.
- Bus outputs are stable for the whole of WAIT. dmem_ack_i outside WAIT is ignored.
- Store alignment, with o = addr[1:0]:
  - SB: be=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - SH: be = o[1] ? 1100 : 0011, wdata={2{wdata[15:0]}}.
  - SW: be=1111.
- Load alignment:
  - Byte select = rdata[8*o+:8]; half select = rdata[16*o[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Loads drive be=1111.
- load_data_o:
  - Updated only on load completion (or cleared on timeout).
  - Held otherwise, including across stores and non-memory instructions.
- flush_i:
  - Only gates start.
  - An access already in WAIT always completes, even if flush_i is asserted with ack in the same cycle.
- Non-memory instructions: stall_o=0, no bus activity.
- Counter: cleared on entry to WAIT, increments each WAIT cycle without ack.

Test Plan:
- LB, addr=0x1003, memory acks on first WAIT cycle with rdata=0x80FF_FF11 -> dmem_addr_o=0x1000, be=1111, stall_o=1 for 2 cycles, load_data_o=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH, addr=0x2002, wdata=0x1234_ABCD, ack after 3 wait cycles -> we=1, be=1100, dmem_wdata_o=0xABCD_ABCD, stall_o high 5 cycles, load_data_o unchanged.
- LW, addr=0x3001 -> misalign_o=1, dmem_req_o stays 0, stall_o=0; LH, addr=0x3003 and funct3=011 behave the same.
- LW, no ack, TIMEOUT_CYCLES=16 -> req falls after 16 WAIT cycles, bus_err_o one-cycle pulse, load_data_o=0, FSM back in IDLE 2 cycles later.
- LW in WAIT with rst_i pulsed low mid-wait -> all outputs 0 immediately, state IDLE; a later ack is ignored.
- flush_i=1 with a valid SW in IDLE -> no req, no stall. Separately: flush_i=1 in the ack cycle of an in-flight LW -> load completes, load_data_o updated.

Source files
------------

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: runs a req/ack data-memory access, lane-aligns stores and
// extends loads, holding the pipeline via stall_o until the access has finished.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;

  logic          misalign, mem_op, start, timeout_hit;
  logic [3:0]    be_st;
  logic [31:0]   wdata_st, load_ext;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  // Unsupported size encodings fall into the misaligned bucket so they never reach the bus.
  always_comb begin
    case (funct3_i)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = addr_i[0];
      3'b010:         misalign = |addr_i[1:0];
      default:        misalign = 1'b1;
    endcase
  end

  assign mem_op      = mem_read_i | mem_write_i;
  assign start       = (state_q == S_IDLE) & valid_i & mem_op & ~flush_i & ~misalign;
  assign misalign_o  = (state_q == S_IDLE) & valid_i & mem_op & misalign;
  assign stall_o     = start | (state_q == S_WAIT);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_st    = 4'b1111;
    wdata_st = wdata_i;
    if (mem_write_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_st    = 4'b0001 << addr_i[1:0];
          wdata_st = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          be_st    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_st = {2{wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign rd_byte = dmem_rdata_i[{off_q, 3'b000} +: 8];
  assign rd_half = dmem_rdata_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    load_d  = load_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = {addr_i[31:2], 2'b00};
          be_d    = be_st;
          wdata_d = wdata_st;
          f3_d    = funct3_i;
          off_d   = addr_i[1:0];
        end
      end
      S_WAIT: begin
        // Ack wins over timeout; flush_i has no effect on an access already issued.
        if (dmem_ack_i) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) load_d = load_ext;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          load_d  = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign load_data_o  = load_q;
  assign bus_err_o    = err_q;
endmodule
